// File: rtl/monitoreo_multicanal_pkg.sv
// Shared types and default thresholds for the multichannel temperature monitor.
// Temperatures are unsigned tenths of degC.
package monitoreo_pkg;

    typedef enum logic [1:0] {
        NORMAL = 2'b00,
        BAJO   = 2'b01,
        ALTO   = 2'b10,
        ALERTA = 2'b11
    } estado_t;

    typedef enum logic [1:0] {
        EN_RANGO = 2'b00,
        FRIO     = 2'b01,
        CALOR    = 2'b10
    } clasif_t;

    localparam int N_CANALES_DEF      = 4;
    localparam int W_TEMP_DEF         = 10;
    localparam int UMBRAL_BAJO_DEF    = 180;
    localparam int UMBRAL_ALTO_DEF    = 260;
    localparam int HISTERESIS_DEF     = 10;
    localparam int CICLOS_PERSIST_DEF = 5;

endpackage

// File: rtl/monitoreo_multicanal_canal.sv
// One supervised channel: classification, persistence FSM with hysteresis recovery,
// direction flag and registered heater/fan/alarm outputs.
module monitoreo_canal
    import monitoreo_pkg::*;
#(
    parameter int W_TEMP         = W_TEMP_DEF,
    parameter int UMBRAL_BAJO    = UMBRAL_BAJO_DEF,
    parameter int UMBRAL_ALTO    = UMBRAL_ALTO_DEF,
    parameter int HISTERESIS     = HISTERESIS_DEF,
    parameter int CICLOS_PERSIST = CICLOS_PERSIST_DEF
) (
    input  logic              clk,
    input  logic              arst,
    input  logic [W_TEMP-1:0] temp,
    input  logic              valida,
    input  logic              hab,
    output logic              alerta,
    output logic              calefactor,
    output logic              ventilador,
    output logic [1:0]        estado
);

    localparam int W_CNT = $clog2(CICLOS_PERSIST + 1);

    localparam logic [W_TEMP-1:0] T_BAJO       = W_TEMP'(UMBRAL_BAJO);
    localparam logic [W_TEMP-1:0] T_ALTO       = W_TEMP'(UMBRAL_ALTO);
    localparam logic [W_TEMP-1:0] T_RECUP_FRIO = W_TEMP'(UMBRAL_BAJO + HISTERESIS);
    localparam logic [W_TEMP-1:0] T_RECUP_CAL  = W_TEMP'(UMBRAL_ALTO - HISTERESIS);
    localparam logic [W_CNT-1:0]  CNT_CERO     = W_CNT'(0);
    localparam logic [W_CNT-1:0]  CNT_UNO      = W_CNT'(1);
    localparam logic [W_CNT-1:0]  CNT_MAX      = W_CNT'(CICLOS_PERSIST);
    localparam logic              PERSIST_UNO  = (CICLOS_PERSIST == 1);

    if (UMBRAL_BAJO >= 2**W_TEMP || UMBRAL_ALTO >= 2**W_TEMP ||
        HISTERESIS >= 2**W_TEMP || UMBRAL_BAJO + HISTERESIS >= 2**W_TEMP) begin : g_err_rango
        $error("monitoreo_canal: threshold does not fit in W_TEMP bits");
    end
    if (UMBRAL_BAJO + HISTERESIS >= UMBRAL_ALTO - HISTERESIS || CICLOS_PERSIST < 1) begin : g_err_param
        $error("monitoreo_canal: inconsistent hysteresis band or CICLOS_PERSIST");
    end

    estado_t            estado_r, estado_s;
    logic [W_CNT-1:0]   cnt_r, cnt_s, cnt_inc_s;
    logic               dir_calor_r, dir_calor_s;
    logic               alerta_r, calefactor_r, ventilador_r;
    clasif_t            clase_s;
    logic               recup_frio_s, recup_calor_s;

    // Classify the incoming sample against the alarm and recovery thresholds.
    always_comb begin
        clase_s = EN_RANGO;
        if (temp < T_BAJO) begin
            clase_s = FRIO;
        end else if (temp >= T_ALTO) begin
            clase_s = CALOR;
        end else begin
            clase_s = EN_RANGO;
        end
        recup_frio_s  = (temp >= T_RECUP_FRIO);
        recup_calor_s = (temp <  T_RECUP_CAL);
    end

    // Next-state, counter and direction logic for one valid sample.
    always_comb begin
        estado_s    = estado_r;
        cnt_s       = cnt_r;
        dir_calor_s = dir_calor_r;
        cnt_inc_s   = cnt_r + CNT_UNO;
        if (!hab) begin
            estado_s    = NORMAL;
            cnt_s       = CNT_CERO;
            dir_calor_s = 1'b0;
        end else if (valida) begin
            case (estado_r)
                NORMAL, BAJO, ALTO, ALERTA: begin
                    // Entering a side from elsewhere always restarts the count at 1.
                    if (clase_s == FRIO && !(estado_r == BAJO ||
                            (estado_r == ALERTA && !dir_calor_r))) begin
                        cnt_s       = CNT_UNO;
                        dir_calor_s = 1'b0;
                        estado_s    = PERSIST_UNO ? ALERTA : BAJO;
                    end else if (clase_s == CALOR && !(estado_r == ALTO ||
                            (estado_r == ALERTA && dir_calor_r))) begin
                        cnt_s       = CNT_UNO;
                        dir_calor_s = 1'b1;
                        estado_s    = PERSIST_UNO ? ALERTA : ALTO;
                    end else if (clase_s != EN_RANGO) begin
                        if (estado_r == ALERTA) begin
                            cnt_s = CNT_MAX;
                        end else begin
                            cnt_s = cnt_inc_s;
                            if (cnt_inc_s == CNT_MAX) begin
                                estado_s = ALERTA;
                            end else begin
                                estado_s = estado_r;
                            end
                        end
                    end else if ((estado_r == BAJO || (estado_r == ALERTA && !dir_calor_r))
                                 && recup_frio_s) begin
                        estado_s = NORMAL;
                        cnt_s    = CNT_CERO;
                    end else if ((estado_r == ALTO || (estado_r == ALERTA && dir_calor_r))
                                 && recup_calor_s) begin
                        estado_s = NORMAL;
                        cnt_s    = CNT_CERO;
                    end else begin
                        estado_s = estado_r;
                    end
                end
                default: begin
                    estado_s    = NORMAL;
                    cnt_s       = CNT_CERO;
                    dir_calor_s = 1'b0;
                end
            endcase
        end else begin
            estado_s = estado_r;
        end
    end

    // State, counter and output registers; outputs derive from the next state.
    always_ff @(posedge clk or posedge arst) begin
        if (arst) begin
            estado_r     <= NORMAL;
            cnt_r        <= CNT_CERO;
            dir_calor_r  <= 1'b0;
            alerta_r     <= 1'b0;
            calefactor_r <= 1'b0;
            ventilador_r <= 1'b0;
        end else begin
            estado_r     <= estado_s;
            cnt_r        <= cnt_s;
            dir_calor_r  <= dir_calor_s;
            alerta_r     <= (estado_s == ALERTA);
            calefactor_r <= (estado_s == BAJO) || (estado_s == ALERTA && !dir_calor_s);
            ventilador_r <= (estado_s == ALTO) || (estado_s == ALERTA &&  dir_calor_s);
        end
    end

    assign alerta     = alerta_r;
    assign calefactor = calefactor_r;
    assign ventilador = ventilador_r;
    assign estado     = estado_r;

endmodule

// File: rtl/monitoreo_multicanal.sv
// N-channel temperature supervisor: independent channel FSMs plus a global alarm
// summary (OR and popcount) taken directly from the registered alarms.
module monitoreo_multicanal
    import monitoreo_pkg::*;
#(
    parameter int N_CANALES      = N_CANALES_DEF,
    parameter int W_TEMP         = W_TEMP_DEF,
    parameter int UMBRAL_BAJO    = UMBRAL_BAJO_DEF,
    parameter int UMBRAL_ALTO    = UMBRAL_ALTO_DEF,
    parameter int HISTERESIS     = HISTERESIS_DEF,
    parameter int CICLOS_PERSIST = CICLOS_PERSIST_DEF
) (
    input  logic                          clk,
    input  logic                          arst,
    input  logic [N_CANALES*W_TEMP-1:0]   temp_entrada,
    input  logic [N_CANALES-1:0]          temp_valida,
    input  logic [N_CANALES-1:0]          canal_hab,
    output logic [N_CANALES-1:0]          alerta,
    output logic [N_CANALES-1:0]          calefactor,
    output logic [N_CANALES-1:0]          ventilador,
    output logic [2*N_CANALES-1:0]        estado_actual,
    output logic                          alerta_global,
    output logic [$clog2(N_CANALES+1)-1:0] num_alertas
);

    localparam int W_NUM = $clog2(N_CANALES + 1);

    for (genvar i = 0; i < N_CANALES; i++) begin : g_canal
        monitoreo_canal #(
            .W_TEMP         (W_TEMP),
            .UMBRAL_BAJO    (UMBRAL_BAJO),
            .UMBRAL_ALTO    (UMBRAL_ALTO),
            .HISTERESIS     (HISTERESIS),
            .CICLOS_PERSIST (CICLOS_PERSIST)
        ) u_canal (
            .clk        (clk),
            .arst       (arst),
            .temp       (temp_entrada[i*W_TEMP +: W_TEMP]),
            .valida     (temp_valida[i]),
            .hab        (canal_hab[i]),
            .alerta     (alerta[i]),
            .calefactor (calefactor[i]),
            .ventilador (ventilador[i]),
            .estado     (estado_actual[2*i +: 2])
        );
    end

    // Alarm summary; combinational so it tracks the registered alarms with no extra cycle.
    always_comb begin
        num_alertas = {W_NUM{1'b0}};
        for (int i = 0; i < N_CANALES; i++) begin
            num_alertas = num_alertas + W_NUM'(alerta[i]);
        end
        alerta_global = |alerta;
    end

endmodule

// File: tb/tb_monitoreo_multicanal.sv
// Directed self-checking bench for monitoreo_multicanal with default parameters.
module tb_monitoreo_multicanal;

    localparam int N = 4;
    localparam int W = 10;

    logic           clk = 1'b0;
    logic           arst;
    logic [N*W-1:0] temp_entrada;
    logic [N-1:0]   temp_valida;
    logic [N-1:0]   canal_hab;
    logic [N-1:0]   alerta;
    logic [N-1:0]   calefactor;
    logic [N-1:0]   ventilador;
    logic [2*N-1:0] estado_actual;
    logic           alerta_global;
    logic [2:0]     num_alertas;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    monitoreo_multicanal dut (
        .clk           (clk),
        .arst          (arst),
        .temp_entrada  (temp_entrada),
        .temp_valida   (temp_valida),
        .canal_hab     (canal_hab),
        .alerta        (alerta),
        .calefactor    (calefactor),
        .ventilador    (ventilador),
        .estado_actual (estado_actual),
        .alerta_global (alerta_global),
        .num_alertas   (num_alertas)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic check_ch0(input string tag, input logic [1:0] est, input logic cal,
                             input logic ven, input logic ale);
        check({tag, "_estado"}, 32'(estado_actual[1:0]), 32'(est));
        check({tag, "_calef"},  32'(calefactor[0]),      32'(cal));
        check({tag, "_vent"},   32'(ventilador[0]),      32'(ven));
        check({tag, "_alerta"}, 32'(alerta[0]),          32'(ale));
    endtask

    task automatic set_temp(input int ch, input int t);
        temp_entrada[ch*W +: W] = W'(t);
    endtask

    task automatic paso();
        @(posedge clk);
        #1;
    endtask

    initial begin
        arst         = 1'b1;
        temp_entrada = {N*W{1'b0}};
        for (int c = 0; c < N; c++) set_temp(c, 220);
        temp_valida  = 4'b0000;
        canal_hab    = 4'b1111;
        #1;
        check("reset_estado", 32'(estado_actual), 32'h0);
        check("reset_alerta", 32'(alerta), 32'h0);
        check("reset_num",    32'(num_alertas), 32'h0);
        @(negedge clk);
        arst = 1'b0;

        // 1: reset in the middle of a cold run
        set_temp(0, 100);
        temp_valida = 4'b0001;
        for (int i = 0; i < 3; i++) paso();
        check_ch0("pre_reset", 2'b01, 1'b1, 1'b0, 1'b0);
        #2;
        arst = 1'b1;
        #1;
        check_ch0("async_reset", 2'b00, 1'b0, 1'b0, 1'b0);
        arst = 1'b0;

        // 2: cold persistence
        set_temp(0, 150);
        for (int i = 1; i <= 6; i++) begin
            paso();
            if (i < 5) begin
                check_ch0("frio_persist", 2'b01, 1'b1, 1'b0, 1'b0);
            end else begin
                check_ch0("frio_alerta", 2'b11, 1'b1, 1'b0, 1'b1);
                check("frio_global", 32'(alerta_global), 32'h1);
                check("frio_num",    32'(num_alertas), 32'h1);
            end
        end

        // 3: hysteresis recovery
        set_temp(0, 185);
        paso();
        check_ch0("histeresis_185", 2'b11, 1'b1, 1'b0, 1'b1);
        set_temp(0, 220);
        paso();
        check_ch0("recup_220", 2'b00, 1'b0, 1'b0, 1'b0);
        check("recup_global", 32'(alerta_global), 32'h0);

        // 4: direction swap restarts the count
        set_temp(0, 300);
        for (int i = 0; i < 4; i++) paso();
        check_ch0("alto_4", 2'b10, 1'b0, 1'b1, 1'b0);
        set_temp(0, 100);
        paso();
        check_ch0("swap_bajo", 2'b01, 1'b1, 1'b0, 1'b0);
        for (int i = 0; i < 3; i++) paso();
        check_ch0("swap_bajo_4", 2'b01, 1'b1, 1'b0, 1'b0);
        paso();
        check_ch0("swap_alerta", 2'b11, 1'b1, 1'b0, 1'b1);
        set_temp(0, 220);
        paso();
        check_ch0("swap_recup", 2'b00, 1'b0, 1'b0, 1'b0);

        // 5: gaps in temp_valida, then enable drop
        set_temp(0, 150);
        for (int i = 1; i <= 5; i++) begin
            temp_valida = 4'b0001;
            paso();
            temp_valida = 4'b0000;
            paso();
            if (i < 5) begin
                check_ch0("gap_hold", 2'b01, 1'b1, 1'b0, 1'b0);
            end else begin
                check_ch0("gap_alerta", 2'b11, 1'b1, 1'b0, 1'b1);
            end
        end
        canal_hab   = 4'b1110;
        temp_valida = 4'b0001;
        paso();
        check_ch0("hab_off", 2'b00, 1'b0, 1'b0, 1'b0);
        canal_hab = 4'b1111;
        for (int i = 0; i < 4; i++) paso();
        check_ch0("hab_cnt_restart", 2'b01, 1'b1, 1'b0, 1'b0);
        set_temp(0, 220);
        paso();
        check_ch0("hab_recup", 2'b00, 1'b0, 1'b0, 1'b0);

        // 6: simultaneous channels
        set_temp(0, 220);
        set_temp(1, 100);
        set_temp(2, 220);
        set_temp(3, 300);
        temp_valida = 4'b1111;
        for (int i = 0; i < 4; i++) paso();
        check("multi_estado_4", 32'(estado_actual), 32'h84);
        check("multi_alerta_4", 32'(alerta), 32'h0);
        paso();
        check("multi_alerta",  32'(alerta), 32'hA);
        check("multi_num",     32'(num_alertas), 32'h2);
        check("multi_global",  32'(alerta_global), 32'h1);
        check("multi_estado",  32'(estado_actual), 32'hCC);
        check("multi_calef",   32'(calefactor), 32'h2);
        check("multi_vent",    32'(ventilador), 32'h8);

        // 7: threshold boundaries on channel 0
        temp_valida = 4'b0000;
        arst = 1'b1;
        #1;
        check("reset2_num", 32'(num_alertas), 32'h0);
        arst = 1'b0;
        temp_valida = 4'b0001;
        set_temp(0, 180);
        paso();
        check_ch0("lim_180", 2'b00, 1'b0, 1'b0, 1'b0);
        set_temp(0, 260);
        paso();
        check_ch0("lim_260", 2'b10, 1'b0, 1'b1, 1'b0);
        set_temp(0, 250);
        paso();
        check_ch0("lim_250", 2'b10, 1'b0, 1'b1, 1'b0);
        set_temp(0, 249);
        paso();
        check_ch0("lim_249", 2'b00, 1'b0, 1'b0, 1'b0);
        set_temp(0, 179);
        paso();
        check_ch0("lim_179", 2'b01, 1'b1, 1'b0, 1'b0);
        set_temp(0, 189);
        paso();
        check_ch0("lim_189", 2'b01, 1'b1, 1'b0, 1'b0);
        set_temp(0, 190);
        paso();
        check_ch0("lim_190", 2'b00, 1'b0, 1'b0, 1'b0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
